// File: rtl/memory_access_unit_if.sv
// Core request/response port plus memory command/reply bus of memory_access_unit.
// The unit binds to the slave modport; the core and memory model sit on the master side.
interface memory_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_code;
   logic [3:0]  cCommand;
   logic [31:0] cAddress;
   logic [31:0] cData;
   logic        hReady;
   logic        hSignal;
   logic [31:0] hData;

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      input  rsp_ready, hReady, hSignal, hData,
      output req_ready, rsp_valid, rsp_rdata, rsp_code, cCommand, cAddress, cData
   );

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      output rsp_ready, hReady, hSignal, hData,
      input  req_ready, rsp_valid, rsp_rdata, rsp_code, cCommand, cAddress, cData
   );
endinterface

// File: rtl/memory_access_unit.sv
// Single-outstanding load/store front end: alignment check, memory command issue,
// reply capture with timeout, and sign/zero-extended response.
module memory_access_unit #(
   parameter int unsigned TIMEOUT = 1023
) (
   input logic                  clock,
   input logic                  reset,
   memory_access_unit_if.slave  bus
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   localparam logic [3:0] MemoryInterfaceCommandNop = 4'h0;
   localparam logic [3:0] MemoryInterfaceCommandRb  = 4'h1;
   localparam logic [3:0] MemoryInterfaceCommandRs  = 4'h2;
   localparam logic [3:0] MemoryInterfaceCommandRw  = 4'h3;
   localparam logic [3:0] MemoryInterfaceCommandWb  = 4'h4;
   localparam logic [3:0] MemoryInterfaceCommandWs  = 4'h5;
   localparam logic [3:0] MemoryInterfaceCommandWw  = 4'h6;

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              write_q, write_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [3:0]        cmd_q, cmd_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [1:0]        code_q, code_d;
   logic              req_ready_q, req_ready_d;
   logic              misaligned;
   logic [31:0]       ext_data;

   assign misaligned = (bus.req_size == 2'b11) ||
                       (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                       (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

   always_comb begin
      case (size_q)
         2'b00:   ext_data = uns_q ? {24'h0, bus.hData[7:0]}
                                   : {{24{bus.hData[7]}}, bus.hData[7:0]};
         2'b01:   ext_data = uns_q ? {16'h0, bus.hData[15:0]}
                                   : {{16{bus.hData[15]}}, bus.hData[15:0]};
         default: ext_data = bus.hData;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      size_d  = size_q;
      uns_d   = uns_q;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rdata_d = rdata_q;
      code_d  = code_q;

      unique case (state_q)
         StIdle: begin
            if (bus.req_valid && req_ready_q) begin
               write_d = bus.req_write;
               size_d  = bus.req_size;
               uns_d   = bus.req_unsigned;
               rdata_d = 32'h0;
               if (misaligned) begin
                  code_d  = 2'b01;
                  state_d = StResp;
               end else begin
                  unique case ({bus.req_write, bus.req_size})
                     3'b000:  cmd_d = MemoryInterfaceCommandRb;
                     3'b001:  cmd_d = MemoryInterfaceCommandRs;
                     3'b010:  cmd_d = MemoryInterfaceCommandRw;
                     3'b100:  cmd_d = MemoryInterfaceCommandWb;
                     3'b101:  cmd_d = MemoryInterfaceCommandWs;
                     default: cmd_d = MemoryInterfaceCommandWw;
                  endcase
                  addr_d  = bus.req_addr;
                  data_d  = bus.req_write ? bus.req_wdata : 32'h0;
                  cnt_d   = '0;
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            // A reply in the same cycle as the timeout wins
            if (bus.hReady) begin
               code_d  = bus.hSignal ? 2'b10 : 2'b00;
               rdata_d = (bus.hSignal || write_q) ? 32'h0 : ext_data;
               cmd_d   = MemoryInterfaceCommandNop;
               addr_d  = 32'h0;
               data_d  = 32'h0;
               state_d = StResp;
            end else if (cnt_q == CntW'(TIMEOUT)) begin
               code_d  = 2'b11;
               rdata_d = 32'h0;
               cmd_d   = MemoryInterfaceCommandNop;
               addr_d  = 32'h0;
               data_d  = 32'h0;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: begin
            if (bus.rsp_ready) begin
               rdata_d = 32'h0;
               code_d  = 2'b00;
               state_d = StIdle;
            end
         end
      endcase

      // Memory must have dropped hReady before the next command can go out
      req_ready_d = (state_d == StIdle) && !bus.hReady;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         write_q     <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         cmd_q       <= MemoryInterfaceCommandNop;
         addr_q      <= 32'h0;
         data_q      <= 32'h0;
         rdata_q     <= 32'h0;
         code_q      <= 2'b00;
         req_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         rdata_q     <= rdata_d;
         code_q      <= code_d;
         req_ready_q <= req_ready_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = (state_q == StResp);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_code  = code_q;
   assign bus.cCommand  = cmd_q;
   assign bus.cAddress  = addr_q;
   assign bus.cData     = data_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: loads, stores, alignment errors, faults,
// timeout, response back-pressure and mid-command reset.
module tb_memory_access_unit;

   localparam logic [3:0] CmdNop = 4'h0;
   localparam logic [3:0] CmdRb  = 4'h1;
   localparam logic [3:0] CmdRs  = 4'h2;
   localparam logic [3:0] CmdRw  = 4'h3;
   localparam logic [3:0] CmdWw  = 4'h6;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   memory_access_unit_if bus_if ();

   memory_access_unit #(.TIMEOUT(4)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      bus_if.req_valid    = 1'b1;
      bus_if.req_write    = wr;
      bus_if.req_size     = size;
      bus_if.req_unsigned = uns;
      bus_if.req_addr     = addr;
      bus_if.req_wdata    = wdata;
      tick();
      bus_if.req_valid    = 1'b0;
   endtask

   task automatic take_rsp();
      bus_if.rsp_ready = 1'b1;
      tick();
      bus_if.rsp_ready = 1'b0;
      check("rsp_taken", bus_if.rsp_valid, 0);
      check("ready_again", bus_if.req_ready, 1);
   endtask

   task automatic run_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                           input logic [31:0] hd, input logic [3:0] cmd_exp,
                           input logic [31:0] exp);
      issue(1'b0, size, uns, addr, 32'hFFFF_FFFF);
      check("ld_cmd", bus_if.cCommand, cmd_exp);
      check("ld_addr", bus_if.cAddress, addr);
      check("ld_cdata", bus_if.cData, 0);
      check("ld_busy", bus_if.req_ready, 0);
      bus_if.hReady = 1'b1;
      bus_if.hData  = hd;
      tick();
      bus_if.hReady = 1'b0;
      bus_if.hData  = 32'h0;
      check("ld_valid", bus_if.rsp_valid, 1);
      check("ld_rdata", bus_if.rsp_rdata, exp);
      check("ld_code", bus_if.rsp_code, 0);
      check("ld_nop", bus_if.cCommand, CmdNop);
      check("ld_addr0", bus_if.cAddress, 0);
      take_rsp();
   endtask

   initial begin
      bus_if.req_valid    = 1'b0;
      bus_if.req_write    = 1'b0;
      bus_if.req_size     = 2'b00;
      bus_if.req_unsigned = 1'b0;
      bus_if.req_addr     = 32'h0;
      bus_if.req_wdata    = 32'h0;
      bus_if.rsp_ready    = 1'b0;
      bus_if.hReady       = 1'b0;
      bus_if.hSignal      = 1'b0;
      bus_if.hData        = 32'h0;

      // Reset state
      #3;
      check("rst_req_ready", bus_if.req_ready, 0);
      check("rst_rsp_valid", bus_if.rsp_valid, 0);
      check("rst_rdata", bus_if.rsp_rdata, 0);
      check("rst_code", bus_if.rsp_code, 0);
      check("rst_cmd", bus_if.cCommand, CmdNop);
      check("rst_addr", bus_if.cAddress, 0);
      check("rst_cdata", bus_if.cData, 0);
      tick();
      reset = 1'b1;
      tick();
      check("post_rst_ready", bus_if.req_ready, 1);

      // Signed byte load, 2-edge latency
      run_load(2'b00, 1'b0, 32'h0000_0103, 32'h0000_00F0, CmdRb, 32'hFFFF_FFF0);
      run_load(2'b00, 1'b1, 32'h0000_0105, 32'h1234_5680, CmdRb, 32'h0000_0080);
      run_load(2'b01, 1'b1, 32'h0000_0102, 32'hABCD_8001, CmdRs, 32'h0000_8001);
      run_load(2'b01, 1'b0, 32'h0000_0102, 32'hABCD_8001, CmdRs, 32'hFFFF_8001);
      run_load(2'b10, 1'b0, 32'h0000_0104, 32'h89AB_CDEF, CmdRw, 32'h89AB_CDEF);

      // Store word held until the reply
      issue(1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF);
      for (int k = 0; k < 3; k++) begin
         check("st_cmd", bus_if.cCommand, CmdWw);
         check("st_addr", bus_if.cAddress, 32'h0000_0200);
         check("st_cdata", bus_if.cData, 32'hDEAD_BEEF);
         if (k < 2) tick();
      end
      bus_if.hReady = 1'b1;
      bus_if.hData  = 32'h5555_5555;
      tick();
      bus_if.hReady = 1'b0;
      check("st_valid", bus_if.rsp_valid, 1);
      check("st_rdata", bus_if.rsp_rdata, 0);
      check("st_code", bus_if.rsp_code, 0);
      check("st_nop", bus_if.cCommand, CmdNop);
      check("st_cdata0", bus_if.cData, 0);
      take_rsp();
      check("st_gap_nop", bus_if.cCommand, CmdNop);

      // Misaligned half and illegal size
      issue(1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0);
      check("mis_valid", bus_if.rsp_valid, 1);
      check("mis_code", bus_if.rsp_code, 2'b01);
      check("mis_nop", bus_if.cCommand, CmdNop);
      take_rsp();
      issue(1'b1, 2'b11, 1'b0, 32'h0000_0100, 32'h1);
      check("ill_valid", bus_if.rsp_valid, 1);
      check("ill_code", bus_if.rsp_code, 2'b01);
      check("ill_rdata", bus_if.rsp_rdata, 0);
      check("ill_nop", bus_if.cCommand, CmdNop);
      take_rsp();

      // Timeout after edge N+5 with TIMEOUT=4
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("to_wait_valid", bus_if.rsp_valid, 0);
         check("to_wait_cmd", bus_if.cCommand, CmdRw);
      end
      tick();
      check("to_valid", bus_if.rsp_valid, 1);
      check("to_code", bus_if.rsp_code, 2'b11);
      check("to_rdata", bus_if.rsp_rdata, 0);
      check("to_nop", bus_if.cCommand, CmdNop);
      bus_if.hReady  = 1'b1;
      bus_if.hSignal = 1'b1;
      bus_if.hData   = 32'hFFFF_FFFF;
      tick();
      bus_if.hReady  = 1'b0;
      bus_if.hSignal = 1'b0;
      bus_if.hData   = 32'h0;
      check("late_valid", bus_if.rsp_valid, 1);
      check("late_code", bus_if.rsp_code, 2'b11);
      check("late_rdata", bus_if.rsp_rdata, 0);
      take_rsp();

      // Memory fault, then back-pressure on the response
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
      bus_if.hReady  = 1'b1;
      bus_if.hSignal = 1'b1;
      bus_if.hData   = 32'h1234_5678;
      tick();
      bus_if.hReady  = 1'b0;
      bus_if.hSignal = 1'b0;
      bus_if.hData   = 32'h0;
      for (int k = 0; k < 3; k++) begin
         check("flt_valid", bus_if.rsp_valid, 1);
         check("flt_code", bus_if.rsp_code, 2'b10);
         check("flt_rdata", bus_if.rsp_rdata, 0);
         check("flt_busy", bus_if.req_ready, 0);
         tick();
      end
      take_rsp();

      // Reset in the middle of a command
      issue(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0);
      check("rm_cmd", bus_if.cCommand, CmdRb);
      #2;
      reset = 1'b0;
      #1;
      check("rm_nop", bus_if.cCommand, CmdNop);
      check("rm_addr", bus_if.cAddress, 0);
      check("rm_ready", bus_if.req_ready, 0);
      tick();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("rm_no_rsp", bus_if.rsp_valid, 0);
      end
      check("rm_ready_back", bus_if.req_ready, 1);
      run_load(2'b00, 1'b1, 32'h0000_0011, 32'h0000_00A5, CmdRb, 32'h0000_00A5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Load/store front end that sits directly upstream of the soft memory model. It accepts one load or store request at a time from the core over a valid/ready handshake and checks alignment. It translates the request into a memory-interface command and waits for the memory's `hReady`/`hSignal` reply. It then returns sign- or zero-extended load data, or an error code, on a valid/ready response port.

## Interface
- `TIMEOUT`, 1023: cycles to wait for `hReady` after issuing a command before aborting; counter width is `$clog2(TIMEOUT+1)`.
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; `reset==0` forces every register to its reset value immediately.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  core takes the response.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_code`  out  2  00 ok, 01 misaligned/illegal size, 10 memory signalled fault, 11 timeout.
- `cCommand`  out  4  memory command (`MemoryInterfaceCommand*` codes).
- `cAddress`  out  32  memory address.
- `cData`  out  32  store data, right-aligned.
- `hReady`  in  1  memory completion.
- `hSignal`  in  1  memory fault, valid when `hReady==1`.
- `hData`  in  32  read data, right-aligned, valid when `hReady==1`.

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE behaviour:
  - `req_ready = 1` only when the state is IDLE and `hReady==0`. The memory must drop `hReady` after seeing NOP before a new command goes out.
  - Accept on `req_valid & req_ready` and latch all request fields.
  - Misaligned access (half with `addr[0]`, word with `addr[1:0]!=0`) or `req_size==11`: no command is issued. Go to RESP with `rsp_code=01`.
  - Otherwise drive the command: RB/RS/RW for loads, WB/WS/WW for stores. Drive `cAddress=req_addr` and `cData=req_wdata` (0 for loads). Go to ISSUE and clear the timeout counter.
- ISSUE behaviour:
  - Hold `cCommand`, `cAddress` and `cData` stable and increment the counter each cycle.
  - `hReady==1`:
    - Capture the reply. `hSignal==1` gives code 10 and rdata 0.
    - A good load gives rdata = `hData` truncated to the size, then extended per `req_unsigned`. A good store gives rdata 0, code 00.
    - `cCommand` becomes NOP; go to RESP.
  - Counter reaches `TIMEOUT` with `hReady==0`: code 11, rdata 0, `cCommand` becomes NOP, go to RESP.
  - `hReady` takes priority over timeout when both occur in the same cycle.
- RESP behaviour: `rsp_valid=1` and the response fields are stable. On `rsp_ready`, return to IDLE.
- The unit never issues HAW or DR. `cCommand` is NOP in every state except ISSUE. Every command is therefore separated from the next by at least one NOP cycle, which is what the memory uses to detect a new command.
- `cAddress`/`cData` are cleared to 0 whenever `cCommand` is NOP.

## Timing
- Reset values: `req_ready=0` while `reset==0` (then 1 on the first clock with `hReady==0`), `rsp_valid=0`, `rsp_rdata=0`, `rsp_code=00`, `cCommand=NOP`, `cAddress=0`, `cData=0`, state IDLE, counter 0.
- Outputs are registered. For a request accepted at edge N:
  - the command is visible after edge N;
  - if `hReady` is sampled high at edge M, `rsp_valid` rises after edge M and `cCommand` returns to NOP in the same cycle.
  - Minimum load/store latency is acceptance to `rsp_valid` = 2 edges.
- Alignment error: `rsp_valid` after edge N+1 with no memory activity.
- Timeout: `rsp_valid` after edge N+1+`TIMEOUT` when `hReady` stays low.
- Only one request can be outstanding. `req_ready=0` from acceptance until the response is taken; a response and a new acceptance never share a cycle.
- Reset asserted mid-ISSUE: `cCommand` goes to NOP asynchronously and the in-flight request is discarded with no response.
- `hReady` pulses seen outside ISSUE are ignored.

## Test plan
- Load byte, addr 0x103, `req_unsigned=0`, memory returns `hData=0x000000F0` one cycle later → RB to 0x103, then NOP, `rsp_rdata=0xFFFFFFF0`, code 00, 2-edge latency.
- Store word 0xDEADBEEF to 0x200 → WW, `cAddress=0x200`, `cData=0xDEADBEEF` held until `hReady`; rdata 0, code 00; NOP for ≥1 cycle before the next command.
- Load half at 0x101, and separately `req_size=11` → code 01 after 1 edge, `cCommand` never leaves NOP.
- `TIMEOUT=4`, RW with `hReady` held low → code 11 after edge N+5, NOP driven. A late `hReady` pulse is ignored.
- Load word with `hReady=1`, `hSignal=1` → code 10, rdata 0. Then hold `rsp_ready=0` for 3 cycles → response stable and `req_ready=0` throughout.
- Assert `reset` low mid-ISSUE → NOP immediately, `rsp_valid` never rises. After release, a new load completes normally.
